// File: rtl/branch_dir_predictor_pkg.sv
// Shared definitions for the gshare direction predictor: default geometry,
// 2-bit counter encodings and the sequential fetch step.
package branch_dir_predictor_pkg;

    localparam int INDEX_WIDTH_DEF = 6;
    localparam int GHR_WIDTH_DEF   = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_dir_predictor_sat_counter2.sv
// Pure combinational 2-bit saturating counter step: increment on taken,
// decrement on not-taken, holding at the strong states.
module sat_counter2
    import branch_dir_predictor_pkg::*;
(
    input  logic [1:0] cnt_in,
    input  logic       inc,
    output logic [1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (inc) begin
            if (cnt_in != 2'(ST)) cnt_out = cnt_in + 2'd1;
        end else begin
            if (cnt_in != 2'(SNT)) cnt_out = cnt_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_dir_predictor.sv
// Gshare direction predictor behind the BTB: zero-latency PHT lookup on the
// fetch PC, speculative GHR shift, and EX-stage training / history repair.
module branch_dir_predictor
    import branch_dir_predictor_pkg::*;
#(
    parameter int         INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int         GHR_WIDTH   = GHR_WIDTH_DEF,
    parameter logic [1:0] CNT_RESET   = 2'(WNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_valid,
    input  logic [31:0]          IF1_pc,
    input  logic                 btb_hit,
    input  logic                 IF1_Branch,
    input  logic                 IF1_Jump,
    input  logic [31:0]          pc_imm_in,
    output logic                 predict_taken,
    output logic [31:0]          predict_pc,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 EX_valid,
    input  logic                 EX_is_branch,
    input  logic [31:0]          EX_pc,
    input  logic [GHR_WIDTH-1:0] EX_ghr,
    input  logic                 EX_taken,
    input  logic                 EX_mispredict,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    localparam int PHT_SIZE = 2 ** INDEX_WIDTH;

    logic [1:0]             pht [PHT_SIZE];
    logic [GHR_WIDTH-1:0]   ghr;
    logic [INDEX_WIDTH-1:0] fetch_idx;
    logic [INDEX_WIDTH-1:0] ex_idx;
    logic [1:0]             cnt;
    logic [1:0]             train_cnt;
    logic                   train_en;
    logic                   repair_en;
    logic                   spec_en;

    // Only the word-index bits of the resolved PC select a PHT entry.
    logic unused_ex_pc_bits;
    assign unused_ex_pc_bits = ^{EX_pc[31:INDEX_WIDTH+2], EX_pc[1:0]};

    assign fetch_idx = IF1_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr);
    assign ex_idx    = EX_pc[INDEX_WIDTH+1:2]  ^ INDEX_WIDTH'(EX_ghr);

    assign cnt           = pht[fetch_idx];
    assign predict_taken = btb_hit && (IF1_Jump || (IF1_Branch && cnt[1]));
    assign predict_pc    = predict_taken ? pc_imm_in : IF1_pc + PC_STEP;
    assign pred_ghr      = ghr;

    assign train_en  = EX_valid && EX_is_branch;
    assign repair_en = EX_valid && EX_mispredict;
    assign spec_en   = fetch_valid && btb_hit && IF1_Branch && !EX_mispredict;

    sat_counter2 u_train_cnt (
        .cnt_in  (pht[ex_idx]),
        .inc     (EX_taken),
        .cnt_out (train_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CNT_RESET;
        end else if (train_en) begin
            pht[ex_idx] <= train_cnt;
        end
    end

    // A resolved mispredict rebuilds history from the EX snapshot and wins
    // over any speculative shift from the fetch in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (repair_en) begin
            ghr <= EX_is_branch ? {EX_ghr[GHR_WIDTH-2:0], EX_taken} : EX_ghr;
        end else if (spec_en) begin
            ghr <= {ghr[GHR_WIDTH-2:0], cnt[1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (train_en && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (repair_en && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_dir_predictor.sv
// Directed bench for branch_dir_predictor: lookup, training, GHR speculation
// and repair, counter saturation, PC wrap and asynchronous reset.
module tb_branch_dir_predictor;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] IF1_pc;
    logic        btb_hit;
    logic        IF1_Branch;
    logic        IF1_Jump;
    logic [31:0] pc_imm_in;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic [5:0]  pred_ghr;
    logic        EX_valid;
    logic        EX_is_branch;
    logic [31:0] EX_pc;
    logic [5:0]  EX_ghr;
    logic        EX_taken;
    logic        EX_mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    branch_dir_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_valid      (fetch_valid),
        .IF1_pc           (IF1_pc),
        .btb_hit          (btb_hit),
        .IF1_Branch       (IF1_Branch),
        .IF1_Jump         (IF1_Jump),
        .pc_imm_in        (pc_imm_in),
        .predict_taken    (predict_taken),
        .predict_pc       (predict_pc),
        .pred_ghr         (pred_ghr),
        .EX_valid         (EX_valid),
        .EX_is_branch     (EX_is_branch),
        .EX_pc            (EX_pc),
        .EX_ghr           (EX_ghr),
        .EX_taken         (EX_taken),
        .EX_mispredict    (EX_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic fv, input logic [31:0] pc, input logic hit,
                             input logic br, input logic jmp, input logic [31:0] imm);
        fetch_valid = fv;
        IF1_pc      = pc;
        btb_hit     = hit;
        IF1_Branch  = br;
        IF1_Jump    = jmp;
        pc_imm_in   = imm;
    endtask

    task automatic set_ex(input logic v, input logic br, input logic [31:0] pc,
                          input logic [5:0] g, input logic tk, input logic mp);
        EX_valid      = v;
        EX_is_branch  = br;
        EX_pc         = pc;
        EX_ghr        = g;
        EX_taken      = tk;
        EX_mispredict = mp;
    endtask

    logic [4:0] exp_inc;
    logic [4:0] exp_dec;
    logic [1:0] exp_back;

    initial begin
        // Expected predict_taken after each resolve on one entry (LSB first).
        exp_inc  = 5'b11111;
        exp_dec  = 5'b00001;
        exp_back = 2'b10;

        rst_n = 1'b0;
        set_fetch(1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 32'h180);
        set_ex(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        #2;
        check("rst_taken", {31'd0, predict_taken}, 32'd0);
        check("rst_pc", predict_pc, 32'h104);
        check("rst_ghr", {26'd0, pred_ghr}, 32'd0);
        check("rst_branches", stat_branches, 32'd0);
        check("rst_mispredicts", stat_mispredicts, 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Two taken resolves on idx 0 while fetch is stalled: 01 -> 10 -> 11.
        set_ex(1'b1, 1'b1, 32'h100, 6'd0, 1'b1, 1'b0);
        tick();
        check("train1_taken", {31'd0, predict_taken}, 32'd1);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        #1;
        check("train2_taken", {31'd0, predict_taken}, 32'd1);
        check("train2_pc", predict_pc, 32'h180);
        check("train2_ghr", {26'd0, pred_ghr}, 32'd0);
        check("train2_branches", stat_branches, 32'd2);

        set_fetch(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h2000);
        #1;
        check("jump_taken", {31'd0, predict_taken}, 32'd1);
        check("jump_pc", predict_pc, 32'h2000);
        tick();
        check("jump_ghr", {26'd0, pred_ghr}, 32'd0);

        // Speculative history 1,0,1: idx 0 (11), idx 2^1=3 (01), idx 2^2=0 (11).
        set_fetch(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h180);
        #1;
        check("spec1_taken", {31'd0, predict_taken}, 32'd1);
        tick();
        check("spec1_ghr", {26'd0, pred_ghr}, 32'd1);
        set_fetch(1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 32'h180);
        #1;
        check("spec2_taken", {31'd0, predict_taken}, 32'd0);
        tick();
        check("spec2_ghr", {26'd0, pred_ghr}, 32'd2);
        #1;
        check("spec3_taken", {31'd0, predict_taken}, 32'd1);
        tick();
        check("spec3_ghr", {26'd0, pred_ghr}, 32'd5);

        // Repair collides with a speculative branch fetch; repair must win.
        set_ex(1'b1, 1'b1, 32'h300, 6'd1, 1'b0, 1'b1);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        fetch_valid = 1'b0;
        #1;
        check("repair_ghr", {26'd0, pred_ghr}, 32'd2);
        check("repair_mispredicts", stat_mispredicts, 32'd1);
        check("repair_branches", stat_branches, 32'd3);

        // Saturation on idx 15^2=13, observed through a stalled lookup of the same PC.
        set_fetch(1'b0, 32'h3C, 1'b1, 1'b1, 1'b0, 32'h500);
        for (int i = 0; i < 5; i++) begin
            set_ex(1'b1, 1'b1, 32'h3C, 6'd2, 1'b1, 1'b0);
            tick();
            check($sformatf("sat_inc%0d", i), {31'd0, predict_taken}, {31'd0, exp_inc[i]});
        end
        for (int i = 0; i < 5; i++) begin
            set_ex(1'b1, 1'b1, 32'h3C, 6'd2, 1'b0, 1'b0);
            tick();
            check($sformatf("sat_dec%0d", i), {31'd0, predict_taken}, {31'd0, exp_dec[i]});
        end
        for (int i = 0; i < 2; i++) begin
            set_ex(1'b1, 1'b1, 32'h3C, 6'd2, 1'b1, 1'b0);
            tick();
            check($sformatf("sat_back%0d", i), {31'd0, predict_taken}, {31'd0, exp_back[i]});
        end
        set_ex(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        #1;
        check("sat_branches", stat_branches, 32'd15);

        // Same-entry train and lookup: old value (10) now, new value (01) next cycle.
        set_ex(1'b1, 1'b1, 32'h3C, 6'd2, 1'b0, 1'b0);
        #1;
        check("bypass_old", {31'd0, predict_taken}, 32'd1);
        tick();
        set_ex(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        #1;
        check("bypass_new", {31'd0, predict_taken}, 32'd0);

        set_fetch(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("wrap_pc", predict_pc, 32'h0);
        check("wrap_taken", {31'd0, predict_taken}, 32'd0);

        // Asynchronous reset mid-flush, after training.
        set_fetch(1'b0, 32'h108, 1'b1, 1'b1, 1'b0, 32'h180);
        #1;
        check("pre_rst_taken", {31'd0, predict_taken}, 32'd1);
        set_ex(1'b1, 1'b0, 32'h400, 6'd3, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ghr", {26'd0, pred_ghr}, 32'd0);
        check("mid_rst_branches", stat_branches, 32'd0);
        check("mid_rst_mispredicts", stat_mispredicts, 32'd0);
        check("mid_rst_taken_idx2", {31'd0, predict_taken}, 32'd0);
        IF1_pc = 32'h100;
        #1;
        check("mid_rst_taken_idx0", {31'd0, predict_taken}, 32'd0);
        check("mid_rst_pc_idx0", predict_pc, 32'h104);
        set_ex(1'b0, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        IF1_pc = 32'h34;
        #1;
        check("post_rst_taken_idx13", {31'd0, predict_taken}, 32'd0);
        tick();
        check("post_rst_ghr", {26'd0, pred_ghr}, 32'd0);
        check("post_rst_branches", stat_branches, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_dir_predictor.md
Name: branch_dir_predictor

Overview:
- Gshare direction predictor that sits directly downstream of the BTB in the fetch path.
- Consumes the BTB lookup result for the current fetch PC (hit, branch/jump type, target) and decides taken/not-taken using a pattern history table (PHT) of 2-bit counters, indexed by PC XOR global history register (GHR).
- Drives the predicted next PC to the PC mux.
- Trained and repaired by the EX-stage branch resolution port.

Parameters:
- INDEX_WIDTH, 6, PHT index bits; PHT has 2**INDEX_WIDTH entries.
- GHR_WIDTH, 6, global history length; must be <= INDEX_WIDTH.
- CNT_RESET, 2'b01, reset value of every PHT counter (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_valid  in  1  fetch advancing this cycle; low = stall, no speculative state change.
- IF1_pc  in  32  current fetch PC.
- btb_hit  in  1  BTB tag hit for IF1_pc.
- IF1_Branch  in  1  BTB entry is a conditional branch.
- IF1_Jump  in  1  BTB entry is a jump.
- pc_imm_in  in  32  BTB target for IF1_pc.
- predict_taken  out  1  prediction for IF1_pc.
- predict_pc  out  32  next fetch PC.
- pred_ghr  out  GHR_WIDTH  GHR snapshot used for this lookup; pipelined with the instruction to EX.
- EX_valid  in  1  resolved control-flow instruction in EX.
- EX_is_branch  in  1  resolved instruction is a conditional branch.
- EX_pc  in  32  PC of the resolved instruction.
- EX_ghr  in  GHR_WIDTH  pred_ghr carried from fetch.
- EX_taken  in  1  actual branch outcome.
- EX_mispredict  in  1  direction or target mispredicted; front end flushes this cycle.
- stat_branches  out  32  resolved conditional branch count.
- stat_mispredicts  out  32  mispredict count.

Behaviour:
- Index: fetch_idx = IF1_pc[INDEX_WIDTH+1:2] XOR zero-extended GHR; ex_idx = EX_pc[INDEX_WIDTH+1:2] XOR zero-extended EX_ghr.
- Lookup is combinational, zero latency: cnt = pht[fetch_idx].
  - predict_taken = btb_hit && (IF1_Jump || (IF1_Branch && cnt[1])).
  - predict_pc = predict_taken ? pc_imm_in : IF1_pc + 32'd4, wrapping mod 2^32.
  - pred_ghr = current GHR register value.
- Speculative GHR update at posedge: when fetch_valid && btb_hit && IF1_Branch && !EX_mispredict, ghr <= {ghr[GHR_WIDTH-2:0], cnt[1]}. Jumps and BTB misses leave GHR unchanged.
- GHR repair at posedge when EX_valid && EX_mispredict:
  - EX_is_branch=1: ghr <= {EX_ghr[GHR_WIDTH-2:0], EX_taken}.
  - EX_is_branch=0: ghr <= EX_ghr.
  - Repair has priority over the speculative shift in the same cycle.
- PHT training at posedge when EX_valid && EX_is_branch:
  - EX_taken=1: pht[ex_idx] increments, saturating at 2'b11.
  - EX_taken=0: pht[ex_idx] decrements, saturating at 2'b00.
  - Training occurs regardless of EX_mispredict.
- Same-entry read/write: a fetch lookup in the same cycle as a training write to the same index sees the pre-write value; the new value is visible the next cycle.
- Stats:
  - stat_branches increments on EX_valid && EX_is_branch.
  - stat_mispredicts increments on EX_valid && EX_mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- fetch_valid=0: outputs still reflect IF1_pc combinationally; no GHR shift. Training and repair still occur.
- Reset (async, any time, including mid-flush): all PHT entries <= CNT_RESET, ghr <= 0, stats <= 0.
  - Outputs during reset: predict_taken=0 unless the BTB hits with IF1_Jump; predict_pc = IF1_pc+4 when not taken.
- EX inputs are ignored when EX_valid=0.

Decomposition:
- Shared package holds:
  - GHR_WIDTH and INDEX_WIDTH defaults.
  - 2-bit counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - The PC_STEP=4 constant.
- One natural sub-module: sat_counter2, a pure 2-bit saturating inc/dec function block reused for the PHT update.

Test Plan:
- Reset, btb_hit=1, IF1_Branch=1, IF1_pc=0x100, pc_imm_in=0x180 -> predict_taken=0, predict_pc=0x104, pred_ghr=0.
- Same PC, resolve twice with EX_taken=1, EX_ghr=0, EX_is_branch=1, fetch stalled (fetch_valid=0) -> counter 01->10->11; next lookup gives predict_taken=1, predict_pc=0x180.
- btb_hit=1, IF1_Jump=1, pc_imm_in=0x2000 -> predict_taken=1, predict_pc=0x2000 regardless of counter; GHR unchanged.
- Three fetch_valid branch lookups predicting 1,0,1 from ghr=0 -> ghr=6'b000101; then EX_mispredict=1, EX_is_branch=1, EX_ghr=6'b000001, EX_taken=0 in the same cycle as a speculative fetch -> ghr=6'b000010.
- Saturation: five taken resolves on one index -> counter stays 11; five not-taken -> stays 00.
- Same-index training and fetch lookup in one cycle -> lookup shows the old counter; the next cycle shows the updated counter.
- IF1_pc=0xFFFF_FFFC on a BTB miss -> predict_pc=0x0000_0000.
- Assert rst_n mid-stream after training -> all counters return to 01, ghr=0, stats=0.
